// File: rtl/fetch_if.sv
// Bundle of the fetch stage's memory-side and decode-side signals.
// master = fetch unit; slave = memory model plus decode.
interface fetch_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_W;
    logic [DATA_W-1:0] mem_din;
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_addr, mem_W, instr_valid, instr, instr_pc,
        input  mem_din, halt, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_addr, mem_W, instr_valid, instr, instr_pc,
        output mem_din, halt, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PCs to a 1-cycle registered-read memory, buffers the
// returned words and hands {pc, instr} to decode. A beat transfers when instr_valid & instr_ready.
module fetch_unit #(
    parameter int              ADDR_W   = 5,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    fetch_if.master    bus,
    output logic [1:0] dbg_state
);
    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_data_q [DEPTH];
    logic [DATA_W-1:0] buf_data_d [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d   [DEPTH];

    logic              valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    assign valid     = (cnt_q != '0);
    assign pop       = valid & bus.instr_ready;
    // Credit counts the in-flight word so a landing word always has a free slot.
    assign occupancy = {1'b0, cnt_q} + (CNT_W + 1)'(inflight_q);
    assign issue     = (state_q == S_RUN) && !bus.halt && !bus.redirect &&
                       (occupancy < DEPTH_L + (CNT_W + 1)'(pop));
    assign push      = inflight_q && !bus.redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;

        case (state_q)
            S_RST:   state_d = S_RUN;
            S_RUN:   if (bus.halt)  state_d = S_HALT;
            S_HALT:  if (!bus.halt) state_d = S_RUN;
            default: state_d = S_RST;
        endcase

        if (bus.redirect) begin
            // Redirect wins over everything: drop buffered and in-flight words.
            pc_d     = bus.redirect_pc;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + ADDR_W'(1);
                inflight_d = 1'b1;
                tag_d      = pc_q;
            end
            if (push) begin
                buf_data_d[wr_ptr_q] = bus.mem_din;
                buf_pc_d[wr_ptr_q]   = tag_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_RST;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            buf_data_q <= '{default: '0};
            buf_pc_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.mem_W       = 1'b0;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? buf_data_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = valid ? buf_pc_q[rd_ptr_q]   : '0;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a registered-read memory model, directed scenarios that
// push expected {pc, instr} beats, and a monitor that pops and compares every handshake.
module tb_fetch_unit;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_HALT = 2'd2;

    logic       clk;
    logic       resetn;
    logic [1:0] dbg_state;

    int tests_run;
    int tests_failed;

    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(5'd0), .DEPTH(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (a == '0) ? 32'h803 : 32'h100 + 32'(a);
    endfunction

    always @(posedge clk) bus.mem_din <= mem_word(bus.mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [ADDR_W-1:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic chk_drained(input string name);
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Holds reset for n edges, checks reset outputs, then releases (caller is in cycle 0).
    task automatic do_reset(input int n);
        resetn = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (n) tick();
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instr", 64'(bus.instr), 64'd0);
        chk("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(S_RST));
        resetn = 1'b1;
    endtask

    // Redirect with decode stalled, then accept exactly n beats from the new pc.
    task automatic redirect_run(input logic [ADDR_W-1:0] pc, input int n);
        logic [ADDR_W-1:0] p;
        p = pc;
        for (int i = 0; i < n; i++) begin
            expect_beat(p);
            p = p + 5'd1;
        end
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        tick();
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        chk("redir_valid_t1", 64'(bus.instr_valid), 64'd0);
        chk("redir_addr_t1", 64'(bus.mem_addr), 64'(pc));
        tick();
        chk("redir_valid_t2", 64'(bus.instr_valid), 64'd0);
        tick();
        chk("redir_valid_t3", 64'(bus.instr_valid), 64'd1);
        chk("redir_pc_t3", 64'(bus.instr_pc), 64'(pc));
        for (int i = 1; i < n; i++) begin
            tick();
            chk("redir_stream_valid", 64'(bus.instr_valid), 64'd1);
        end
        tick();
        bus.instr_ready = 1'b0;
        chk_drained("redir_drained");
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (resetn === 1'b1) begin
            chk("mem_W", 64'(bus.mem_W), 64'd0);
            if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_pc", 64'(bus.instr_pc), 64'h7fff);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({bus.instr_pc, bus.instr}), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        resetn          = 1'b0;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;

        // 1: streaming after reset, one beat per cycle from cycle 3
        do_reset(2);
        for (int i = 0; i < 6; i++) expect_beat(5'(i));
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 5) chk("s1_mem_addr", 64'(bus.mem_addr), 64'(k - 1));
            chk("s1_valid", 64'(bus.instr_valid), 64'(k >= 3));
        end
        tick();
        bus.instr_ready = 1'b0;
        chk_drained("s1_drained");

        // 2: decode stall fills the buffer, head held, then drains in order
        do_reset(1);
        for (int i = 0; i < 4; i++) expect_beat(5'(i));
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k >= 3) chk("s2_addr_frozen", 64'(bus.mem_addr), 64'd2);
            if (k >= 4) begin
                chk("s2_head_valid", 64'(bus.instr_valid), 64'd1);
                chk("s2_head_pc", 64'(bus.instr_pc), 64'd0);
                chk("s2_head_instr", 64'(bus.instr), 64'h803);
            end
        end
        tick();
        bus.instr_ready = 1'b1;
        for (int k = 8; k <= 11; k++) begin
            chk("s2_drain_valid", 64'(bus.instr_valid), 64'd1);
            tick();
        end
        bus.instr_ready = 1'b0;
        chk_drained("s2_drained");

        // 3: redirect with a buffered word and one in flight
        redirect_run(5'd20, 4);

        // 4: wrap from 31 to 0
        redirect_run(5'd30, 4);

        // 5: halt one cycle after an issue
        expect_beat(5'd8);
        expect_beat(5'd9);
        expect_beat(5'd10);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd8;
        tick();
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        chk("s5_addr_t1", 64'(bus.mem_addr), 64'd8);
        tick();
        bus.halt = 1'b1;
        chk("s5_addr_t2", 64'(bus.mem_addr), 64'd9);
        for (int k = 3; k <= 6; k++) begin
            tick();
            chk("s5_addr_held", 64'(bus.mem_addr), 64'd9);
            chk("s5_valid", 64'(bus.instr_valid), 64'(k == 3));
            if (k == 4) chk("s5_state_halt", 64'(dbg_state), 64'(S_HALT));
        end
        bus.halt = 1'b0;
        tick();
        chk("s5_resume_addr", 64'(bus.mem_addr), 64'd9);
        chk("s5_resume_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        chk("s5_next_addr", 64'(bus.mem_addr), 64'd10);
        tick();
        chk("s5_pc9", 64'(bus.instr_pc), 64'd9);
        tick();
        chk("s5_pc10", 64'(bus.instr_pc), 64'd10);
        tick();
        bus.instr_ready = 1'b0;
        chk_drained("s5_drained");

        // 6: reset in the middle of a stream
        expect_beat(5'd4);
        expect_beat(5'd5);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 5'd4;
        tick();
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (4) tick();
        bus.instr_ready = 1'b0;
        chk_drained("s6_pre_drained");
        do_reset(1);
        expect_beat(5'd0);
        expect_beat(5'd1);
        bus.instr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("s6_valid", 64'(bus.instr_valid), 64'(k >= 3));
        end
        tick();
        bus.instr_ready = 1'b0;
        chk_drained("s6_drained");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
